// File: rtl/debounce_bank.sv
// ============================================================================
//  Module      : debounce_bank
//  Description : Multi-channel button conditioner. Each channel has a 2-flop
//                synchroniser, optional polarity inversion, tick-based
//                stable-count debounce, press/release pulses and a
//                press-toggled latch with synchronous clear. All channels
//                share a single sample-tick divider.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_bank #(
  parameter int              N_CH         = 4,
  parameter int              TICK_DIV     = 100000,
  parameter int              STABLE_TICKS = 10,
  parameter logic [N_CH-1:0] POLARITY     = {N_CH{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_i,
  input  logic [N_CH-1:0] clr_toggle_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] toggle_o
);

  // A divider of 1 still needs a 1-bit counter that simply stays at 0.
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);

  localparam logic [TW-1:0] c_tick_last = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] c_cnt_last  = CW'(STABLE_TICKS - 1);

  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;
  logic [TW-1:0]   r_tick_cnt;
  logic            w_tick;
  logic [N_CH-1:0] w_raw;

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_i;
      r_sync2 <= r_sync1;
    end
  end

  // Shared sample-tick divider: counts 0..TICK_DIV-1 and wraps.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tick_cnt <= '0;
    end else if (r_tick_cnt == c_tick_last) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  assign w_tick = (r_tick_cnt == c_tick_last);

  // Active-low channels are flipped after synchronisation so that the
  // debounce logic always sees "1 = pressed".
  assign w_raw = r_sync2 ^ POLARITY;

  genvar g;
  generate
    for (g = 0; g < N_CH; g = g + 1) begin : g_ch
      logic [CW-1:0] r_cnt;
      logic          r_level;
      logic          r_press;
      logic          r_release;
      logic          r_toggle;
      logic          w_diff;
      logic          w_flip;

      assign w_diff = (w_raw[g] != r_level);
      // Level changes on the tick that completes STABLE_TICKS differing samples.
      assign w_flip = w_tick && w_diff && (r_cnt == c_cnt_last);

      // Stable-sample counter: any agreeing sample discards progress.
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_cnt <= '0;
        end else if (w_tick) begin
          if (!w_diff || (r_cnt == c_cnt_last)) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      end

      // Level, edge pulses and toggle latch all update on the flip edge.
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_level   <= 1'b0;
          r_press   <= 1'b0;
          r_release <= 1'b0;
          r_toggle  <= 1'b0;
        end else begin
          if (w_flip) begin
            r_level <= w_raw[g];
          end
          r_press   <= w_flip &  w_raw[g];
          r_release <= w_flip & ~w_raw[g];
          if (clr_toggle_i[g]) begin
            r_toggle <= 1'b0;
          end else if (w_flip && w_raw[g]) begin
            r_toggle <= ~r_toggle;
          end
        end
      end

      assign level_o[g]   = r_level;
      assign press_o[g]   = r_press;
      assign release_o[g] = r_release;
      assign toggle_o[g]  = r_toggle;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_debounce_bank.sv
// ============================================================================
//  Module      : tb_debounce_bank
//  Description : Self-checking bench for debounce_bank. Two instances share
//                the stimulus: one all active-high, one with channel 3
//                active-low. A behavioural model predicts every output on
//                every cycle; directed scenarios add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debounce_bank;

  localparam int         TDIV = 4;
  localparam int         ST   = 3;
  localparam logic [3:0] POLB = 4'b1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] clr;
  logic [3:0] lv_a, pr_a, rl_a, tg_a;
  logic [3:0] lv_b, pr_b, rl_b, tg_b;

  always #5 clk = ~clk;

  debounce_bank #(.N_CH(4), .TICK_DIV(TDIV), .STABLE_TICKS(ST), .POLARITY(4'b0000)) dut_a (
    .clk(clk), .rst(rst), .btn_i(btn), .clr_toggle_i(clr),
    .level_o(lv_a), .press_o(pr_a), .release_o(rl_a), .toggle_o(tg_a)
  );

  debounce_bank #(.N_CH(4), .TICK_DIV(TDIV), .STABLE_TICKS(ST), .POLARITY(POLB)) dut_b (
    .clk(clk), .rst(rst), .btn_i(btn), .clr_toggle_i(clr),
    .level_o(lv_b), .press_o(pr_b), .release_o(rl_b), .toggle_o(tg_b)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Behavioural model: sampled input history, cycles since reset exit and,
  // per channel, the length of the current run of differing tick samples.
  logic [3:0] m_s1, m_s2;
  int         m_t;
  logic [3:0] m_lvl [2];
  logic [3:0] m_prs [2];
  logic [3:0] m_rel [2];
  logic [3:0] m_tog [2];
  int         m_run [2][4];

  // Event counters for dut_a (pc/rc/lc) and dut_b channel 3 (pcb3).
  int pc [4];
  int rc [4];
  int lc [4];
  int pcb3;
  int both02;
  logic [3:0] prev_lv;

  task automatic model_step();
    bit   tk;
    logic raw;
    logic [3:0] pol;
    if (!rst) begin
      m_s1 = '0; m_s2 = '0; m_t = 0;
      for (int k = 0; k < 2; k++) begin
        m_lvl[k] = '0; m_prs[k] = '0; m_rel[k] = '0; m_tog[k] = '0;
        for (int i = 0; i < 4; i++) m_run[k][i] = 0;
      end
    end else begin
      tk  = ((m_t % TDIV) == TDIV - 1);
      m_t = m_t + 1;
      for (int k = 0; k < 2; k++) begin
        pol = (k == 0) ? 4'b0000 : POLB;
        for (int i = 0; i < 4; i++) begin
          raw = m_s2[i] ^ pol[i];
          m_prs[k][i] = 1'b0;
          m_rel[k][i] = 1'b0;
          if (tk) begin
            if (raw == m_lvl[k][i]) begin
              m_run[k][i] = 0;
            end else begin
              m_run[k][i] = m_run[k][i] + 1;
              if (m_run[k][i] == ST) begin
                m_lvl[k][i] = raw;
                m_run[k][i] = 0;
                if (raw) m_prs[k][i] = 1'b1;
                else     m_rel[k][i] = 1'b1;
              end
            end
          end
          if (clr[i])           m_tog[k][i] = 1'b0;
          else if (m_prs[k][i]) m_tog[k][i] = ~m_tog[k][i];
        end
      end
      m_s2 = m_s1;
      m_s1 = btn;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cycle);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) begin pc[i] = 0; rc[i] = 0; lc[i] = 0; end
    pcb3 = 0; both02 = 0;
  endtask

  // One clock: advance the model, compare both instances after the edge,
  // accumulate event counts, then return at the falling edge for driving.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    cycle++;
    checks++;
    if ({lv_a, pr_a, rl_a, tg_a} !== {m_lvl[0], m_prs[0], m_rel[0], m_tog[0]}) begin
      errors++;
      $display("FAIL model_a cycle %0d: lvl/prs/rel/tog got %h %h %h %h expected %h %h %h %h",
               cycle, lv_a, pr_a, rl_a, tg_a, m_lvl[0], m_prs[0], m_rel[0], m_tog[0]);
    end
    checks++;
    if ({lv_b, pr_b, rl_b, tg_b} !== {m_lvl[1], m_prs[1], m_rel[1], m_tog[1]}) begin
      errors++;
      $display("FAIL model_b cycle %0d: lvl/prs/rel/tog got %h %h %h %h expected %h %h %h %h",
               cycle, lv_b, pr_b, rl_b, tg_b, m_lvl[1], m_prs[1], m_rel[1], m_tog[1]);
    end
    for (int i = 0; i < 4; i++) begin
      pc[i] += int'(pr_a[i]);
      rc[i] += int'(rl_a[i]);
      if (lv_a[i] !== prev_lv[i]) lc[i]++;
    end
    prev_lv = lv_a;
    pcb3   += int'(pr_b[3]);
    if (pr_a[0] && pr_a[2]) both02++;
    @(negedge clk);
  endtask

  // Step until dut_a level_o[ch] reads val; n = cycles taken (0 = timeout).
  task automatic wait_level(input int ch, input logic val, input int limit, output int n);
    n = 0;
    for (int j = 1; j <= limit; j++) begin
      cyc();
      if (lv_a[ch] === val) begin
        n = j;
        break;
      end
    end
  endtask

  int n;

  initial begin
    rst = 1'b0; btn = 4'hF; clr = 4'h0; prev_lv = 4'h0;
    clear_counts();

    // Reset with all buttons high.
    repeat (5) cyc();
    chk("reset_outputs_a", int'({lv_a, pr_a, rl_a, tg_a}), 0);
    chk("reset_outputs_b", int'({lv_b, pr_b, rl_b, tg_b}), 0);

    rst = 1'b1; btn = 4'h0;
    clear_counts();
    repeat (50) cyc();
    chk("reset_exit_press_count", pc[0] + pc[1] + pc[2] + pc[3], 0);
    chk("reset_exit_release_count", rc[0] + rc[1] + rc[2] + rc[3], 0);
    chk("reset_exit_level_a", int'(lv_a), 0);
    chk("polarity_ch3_press_count", pcb3, 1);
    chk("polarity_ch3_level", int'(lv_b[3]), 1);

    // Clean press on channel 0.
    clear_counts();
    btn[0] = 1'b1;
    wait_level(0, 1'b1, 40, n);
    chk_range("clean_press_latency", n, 11, 14);
    chk("press_same_edge", int'(pr_a[0]), 1);
    chk("toggle_after_press", int'(tg_a[0]), 1);
    chk("other_levels", int'(lv_a[3:1]), 0);
    cyc();
    chk("press_one_cycle", int'(pr_a[0]), 0);
    chk("press_count_ch0", pc[0], 1);

    // Bouncing channel 1: toggles every 3 cycles, then settles high.
    clear_counts();
    for (int j = 0; j < 30; j++) begin
      if (j % 3 == 0) btn[1] = ~btn[1];
      cyc();
    end
    chk("bounce_no_press", pc[1], 0);
    chk("bounce_no_level_change", lc[1], 0);
    btn[1] = 1'b1;
    repeat (20) cyc();
    chk("bounce_settled_press", pc[1], 1);
    chk("bounce_level_changes", lc[1], 1);

    // Release then press again on channel 0.
    clear_counts();
    btn[0] = 1'b0;
    repeat (20) cyc();
    chk("release_count", rc[0], 1);
    chk("toggle_across_release", int'(tg_a[0]), 1);
    chk("level_after_release", int'(lv_a[0]), 0);
    btn[0] = 1'b1;
    repeat (20) cyc();
    chk("second_press_count", pc[0], 1);
    chk("toggle_after_second_press", int'(tg_a[0]), 0);

    btn = 4'h0;
    repeat (20) cyc();

    // Simultaneous presses on ch0/ch2 with a clear of ch0 on the press edge.
    clear_counts();
    btn[0] = 1'b1; btn[2] = 1'b1;
    repeat (8) cyc();
    clr[0] = 1'b1;
    for (int j = 0; j < 20 && !pr_a[0]; j++) cyc();
    clr[0] = 1'b0;
    repeat (5) cyc();
    chk("concurrent_press_same_cycle", both02, 1);
    chk("clear_beats_press", int'(tg_a[0]), 0);
    chk("toggle_ch2", int'(tg_a[2]), 1);

    // Mid-debounce reset on channel 2.
    btn[2] = 1'b0;
    repeat (20) cyc();
    btn[2] = 1'b1;
    repeat (7) cyc();
    rst = 1'b0;
    cyc();
    chk("mid_reset_outputs", int'({lv_a, pr_a, rl_a, tg_a}), 0);
    rst = 1'b1;
    wait_level(2, 1'b1, 40, n);
    chk("restart_latency_after_reset", n, 12);

    // Randomised traffic.
    for (int j = 0; j < 2000; j++) begin
      if ($urandom_range(0, 19) == 0) btn[$urandom_range(0, 3)] ^= 1'b1;
      clr = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
      rst = ($urandom_range(0, 299) != 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Parametrised multi-channel button conditioner; the next generation of the single-channel debouncer.
- Per channel: 2-flop synchroniser, optional polarity inversion and tick-based stable-count debounce.
- Per channel outputs: debounced level, one-cycle press/release pulses and a press-toggled latch with clear.
- Sits between board buttons/switches and the counter/control logic in top-level designs; one shared internal sample-tick divider.

Parameters:
- N_CH, 4: number of independent input channels (>=1).
- TICK_DIV, 100000: clk cycles per debounce sample tick (>=1; 1 = sample every cycle).
- STABLE_TICKS, 10: consecutive ticks with input differing from the current level needed to change that level (>=1).
- POLARITY, {N_CH{1'b0}}: per-channel mask; bit=1 means the input is active-low and is inverted after the synchroniser.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous and active-low. rst==0 at a clk posedge resets the block.
- btn_i  in  N_CH  raw asynchronous button/switch inputs.
- clr_toggle_i  in  N_CH  synchronous per-channel clear of toggle_o.
- level_o  out  N_CH  debounced, polarity-corrected level.
- press_o  out  N_CH  one-cycle pulse on each debounced 0->1 transition.
- release_o  out  N_CH  one-cycle pulse on each debounced 1->0 transition.
- toggle_o  out  N_CH  flips on each press; cleared by clr_toggle_i.

Behaviour:
- Reset (rst==0 at posedge):
  - Synchroniser flops, tick counter and all per-channel stable counters go to 0.
  - level_o, press_o, release_o and toggle_o all go to 0.
  - Reset overrides every other input in that cycle, including mid-debounce.
- Synchroniser: btn_i passes through 2 flops. raw[i] = sync2[i] XOR POLARITY[i].
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick=1 for exactly the one cycle in which the counter equals TICK_DIV-1.
  - TICK_DIV=1 gives tick=1 every cycle.
- Per-channel debounce, evaluated only on tick cycles; non-tick cycles hold all counters:
  - raw==level: cnt<=0.
  - raw!=level and cnt==STABLE_TICKS-1: level<=raw, cnt<=0.
  - Otherwise: cnt<=cnt+1.
  - Counter width is $clog2(STABLE_TICKS+1); it never exceeds STABLE_TICKS-1.
  - A glitch shorter than STABLE_TICKS ticks therefore never changes the level and resets progress.
- Pulses:
  - press_o[i] is registered and is 1 exactly in the cycle where level_o[i] first reads 1 (same edge as the level update); 0 otherwise.
  - release_o[i] behaves the same way for the first cycle where level_o[i] reads 0.
  - No pulse is generated at reset exit.
- Toggle latch:
  - On a press edge toggle<=~toggle.
  - clr_toggle_i[i]=1 forces toggle<=0 and has priority over a simultaneous press.
- Latency: a clean input edge reaches level_o after 2 sync cycles plus STABLE_TICKS ticks. The total lies between 2+(STABLE_TICKS-1)*TICK_DIV+1 and 2+STABLE_TICKS*TICK_DIV cycles, depending on tick phase.
- Channels are fully independent. Simultaneous events on several channels produce pulses in the same cycle.
- Polarity edge case: an active-low channel held high at reset exit reads raw=1 while level=0. It therefore debounces to 1 and emits one press pulse STABLE_TICKS ticks after reset exit.

Test Plan (N_CH=4, TICK_DIV=4, STABLE_TICKS=3, POLARITY=4'b0000 unless stated):
- Reset: rst=0 for 5 cycles with btn_i=4'hF, then rst=1 with btn_i=0 -> all outputs 0 throughout; no pulses for 50 cycles.
- Clean press ch0: btn_i[0] 0->1 held -> level_o[0]=1 between 11 and 14 cycles later; press_o[0] high exactly 1 cycle, on the same edge; toggle_o[0]=1; other channels unchanged.
- Bounce ch1: btn_i[1] toggles every 3 cycles for 30 cycles, then held 1 -> zero press pulses during the bounce; exactly one press_o[1] pulse after it settles; level_o[1] changes once.
- Release and toggle: press ch0, release, press again -> one release_o[0] pulse; toggle_o[0] goes 1->1 across the release, then 0 on the second press.
- Priority and concurrency: btn_i[0] and btn_i[2] rise in the same cycle, with clr_toggle_i[0]=1 in the press cycle -> press_o[0] and press_o[2] pulse in the same cycle; toggle_o[0]=0, toggle_o[2]=1.
- Polarity and mid-operation reset:
  - POLARITY=4'b1000, btn_i[3]=0 held -> level_o[3]=1 and one press pulse.
  - Assert rst=0 for 1 cycle mid-debounce of ch2 -> outputs 0; the debounce restarts from cnt=0 after reset.
